// File: rtl/uart_pkg.sv
// Shared UART definitions: baud assumptions, frame geometry and FSM state encoding.
// Used by the transmitter now and by the receiver once it moves onto this package.
package uart_pkg;

  localparam int CLK_HZ       = 50_000_000;
  localparam int BAUD         = 9600;
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int DATA_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit period. clr_i holds the count at zero between frames.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_end_o
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  assign bit_end_o = en_i && (cnt_q == LAST);

  // Free-running bit-period count that wraps on the last cycle of each bit.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits, LSB first, 1 or 2 stop bits, idle-high line.
// A one-entry holding register sits in front of the shift register so the next
// byte can be queued while a frame is on the wire, giving gap-free back-to-back frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 data_valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] hold_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 ready_q;
  logic                 tx_q;
  logic                 busy_q;
  logic [2:0]           bit_idx_q;
  logic                 stop_cnt_q;
  logic                 bit_end;

  // The counter idles at zero, so every frame starts on a fresh bit period.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == IDLE),
    .en_i     (state_q != IDLE),
    .bit_end_o(bit_end)
  );

  assign ready = ready_q;
  assign tx    = tx_q;
  assign busy  = busy_q;

  // Handshake into the holding register plus the frame sequencer. ready_q is
  // the "holding register empty" flag, so an accept and a load never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      if (data_valid && ready_q) begin
        hold_q  <= data;
        ready_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!ready_q) begin
            shift_q <= hold_q;
            ready_q <= 1'b1;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end

        START: begin
          if (bit_end) begin
            tx_q      <= shift_q[0];
            bit_idx_q <= '0;
            state_q   <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_idx_q == LAST_BIT) begin
              tx_q       <= 1'b1;
              stop_cnt_q <= 1'b0;
              state_q    <= STOP;
            end else begin
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end

        STOP: begin
          if (bit_end) begin
            if (stop_cnt_q != LAST_STOP) begin
              stop_cnt_q <= 1'b1;
            end else if (!ready_q) begin
              // Queued byte goes straight into a new start bit: no idle gap.
              shift_q <= hold_q;
              ready_q <= 1'b1;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits) at 4 clocks per bit.
// Bytes are queued as expected results when accepted; a line monitor decodes
// each frame from tx, checks bit widths and framing, and compares against the queue.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [7:0] data_a = '0;
  logic [7:0] data_b = '0;
  logic       dv_a = 1'b0;
  logic       dv_b = 1'b0;
  logic       ready_a, tx_a, busy_a;
  logic       ready_b, tx_b, busy_b;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];
  int         falls_a[$];
  int         falls_b[$];

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .data(data_a), .data_valid(dv_a),
    .ready(ready_a), .tx(tx_a), .busy(busy_a)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .data(data_b), .data_valid(dv_b),
    .ready(ready_b), .tx(tx_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic txv(input int id);
    return (id == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic rdy(input int id);
    return (id == 0) ? ready_a : ready_b;
  endfunction

  function automatic logic bsy(input int id);
    return (id == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic [2:0] outs(input int id);
    return {txv(id), rdy(id), bsy(id)};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_for(input int id, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, outs(id), 3'b110);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge, acc = that edge's number.
  task automatic send(input int id, input logic [7:0] b, output int acc);
    int n;
    n = 0;
    if (id == 0) begin data_a = b; dv_a = 1'b1; end
    else         begin data_b = b; dv_b = 1'b1; end
    while (!rdy(id) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(id)) begin
      check("send_timeout", 32'(rdy(id)), 32'd1);
      acc = -1;
    end else begin
      if (id == 0) sb_a.push_back(b);
      else         sb_b.push_back(b);
      @(negedge clk);
      acc = cyc;
    end
    if (id == 0) dv_a = 1'b0;
    else         dv_b = 1'b0;
  endtask

  task automatic measure(input int id, output int t_busy, output int n_busy, output int n_low);
    int n;
    n = 0; n_busy = 0; n_low = 0; t_busy = -1;
    while (!bsy(id) && n < 50) begin
      @(negedge clk);
      n++;
    end
    t_busy = cyc;
    while (bsy(id) && n_busy < 200) begin
      n_busy++;
      if (!txv(id)) n_low++;
      @(negedge clk);
    end
  endtask

  task automatic monitor(input int id, input int cpb, input int nstop);
    logic [7:0] b;
    logic       lvl, first;
    bit         bad, abort;
    int         fall;
    forever begin
      @(negedge clk);
      if (!rst && txv(id) == 1'b0) begin
        fall = cyc; bad = 0; abort = 0; b = '0; first = 1'b0;
        for (int k = 0; k < 9 + nstop && !abort; k++) begin
          for (int c = 0; c < cpb && !abort; c++) begin
            if (k != 0 || c != 0) @(negedge clk);
            if (rst) abort = 1;
            else begin
              lvl = txv(id);
              if (c == 0) first = lvl;
              else if (lvl != first) bad = 1;
            end
          end
          if (!abort) begin
            if (k == 0 && first != 1'b0) bad = 1;
            if (k >= 1 && k <= 8) b[k-1] = first;
            if (k >= 9 && first != 1'b1) bad = 1;
          end
        end
        if (!abort) begin
          check(id == 0 ? "frame_shape_a" : "frame_shape_b", 32'(bad), 32'd0);
          if (id == 0) begin
            falls_a.push_back(fall);
            check("rx_pending_a", 32'(sb_a.size() > 0), 32'd1);
            if (sb_a.size() > 0) check("rx_byte_a", b, sb_a.pop_front());
          end else begin
            falls_b.push_back(fall);
            check("rx_pending_b", 32'(sb_b.size() > 0), 32'd1);
            if (sb_b.size() > 0) check("rx_byte_b", b, sb_b.pop_front());
          end
        end
      end
    end
  endtask

  initial monitor(0, CPB, 1);
  initial monitor(1, CPB, 2);

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int         acc, acc2, t, nb, nl, base, n;
    logic [7:0] lb [4];
    lb = '{8'h00, 8'hFF, 8'h80, 8'h01};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset, then a one-cycle reset while idle.
    idle_for(0, 20, "idle_a");
    idle_for(1, 2, "idle_b");
    rst = 1'b1;
    @(negedge clk);
    check("rst_idle", outs(0), 3'b110);
    rst = 1'b0;
    idle_for(0, 3, "idle_post_rst");

    // Single byte 0x55.
    send(0, 8'h55, acc);
    check("t2_ready_low", 32'(rdy(0)), 32'd0);
    check("t2_tx_high_on_accept", 32'(txv(0)), 32'd1);
    measure(0, t, nb, nl);
    check("t2_latency", t - acc, 1);
    check("t2_busy_len", nb, 40);
    check("t2_low_cycles", nl, 20);
    check("t2_idle_after", outs(0), 3'b110);
    wait_cycles(2);
    check("t2_fall_latency", falls_a[falls_a.size()-1] - acc, 1);

    // Back-to-back 0xA5 then 0x3C held until accepted.
    wait_cycles(4);
    base = falls_a.size();
    send(0, 8'hA5, acc);
    send(0, 8'h3C, acc2);
    check("t3_accept_gap", acc2 - acc, 2);
    n = 0;
    while (!rdy(0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t3_ready_rise", cyc - acc, 41);
    wait_cycles(60);
    check("t3_frames", falls_a.size() - base, 2);
    if (falls_a.size() >= base + 2)
      check("t3_no_gap", falls_a[base+1] - falls_a[base], 40);
    check("t3_idle_after", outs(0), 3'b110);

    // Two stop bits, 0x00.
    send(1, 8'h00, acc);
    measure(1, t, nb, nl);
    check("t4_latency", t - acc, 1);
    check("t4_busy_len", nb, 44);
    check("t4_low_cycles", nl, 36);
    check("t4_idle_after", outs(1), 3'b110);

    // Reset during data bit 3 of 0xFF with 0x12 pending.
    wait_cycles(4);
    send(0, 8'hFF, acc);
    send(0, 8'h12, acc2);
    n = 0;
    while (cyc < acc + 18 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_in_frame", {busy_a, ready_a}, 2'b10);
    rst = 1'b1;
    sb_a.delete();
    @(negedge clk);
    check("t5_rst_outputs", outs(0), 3'b110);
    @(negedge clk);
    rst = 1'b0;
    idle_for(0, 6, "t5_idle");
    base = falls_a.size();
    send(0, 8'h34, acc);
    wait_cycles(60);
    check("t5_frames_after_rst", falls_a.size() - base, 1);

    // Four bytes back-to-back through the line decoder.
    base = falls_a.size();
    for (int i = 0; i < 4; i++) send(0, lb[i], acc);
    wait_cycles(200);
    check("t6_frames", falls_a.size() - base, 4);
    if (falls_a.size() >= base + 4)
      for (int i = 1; i < 4; i++)
        check("t6_no_gap", falls_a[base+i] - falls_a[base+i-1], 40);

    check("sb_a_empty", sb_a.size(), 0);
    check("sb_b_empty", sb_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
